xor_accum_unit: RTL and testbench



---
 rtl/xor_accum_unit.sv | 104 ++++++++++
 tb/tb_xor_accum_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/xor_accum_unit.sv
// xor_accum_unit: XOR/XNOR accumulator over a programmed number of words, accepted with a
// valid/ready handshake. The result goes onto a WIDTH+1 bit three-state result bus.
// Optional build macro XOR_ACCUM_PARITY_BIT_EN: when defined, the bus MSB carries the
// odd-weight flag of the result instead of a constant zero.
module xor_accum_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MAX_WORDS = 16,
    localparam int unsigned CW = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CW-1:0]    len,
    input  logic             mode,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    input  logic             EN,
    output logic [WIDTH:0]   s
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [CW-1:0] MaxLen = CW'(MAX_WORDS);
    localparam logic [CW-1:0] OneLen = CW'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [CW-1:0]    len_clamped;
    logic [WIDTH-1:0] res;
    logic             msb;

    // Oversized lengths are clamped once, when the length is captured.
    assign len_clamped = (len > MaxLen) ? MaxLen : len;

    // State register with synchronous reset; reset also discards any transfer in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state and handshake/status outputs; start behaves the same in IDLE and DONE.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                done = (state_q == StDone);
                if (start) begin
                    acc_d   = '0;
                    mode_d  = mode;
                    cnt_d   = len_clamped;
                    state_d = (len_clamped == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    acc_d = acc_q ^ in_data;
                    cnt_d = cnt_q - OneLen;
                    if (cnt_q == OneLen) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign res = mode_q ? ~acc_q : acc_q;

`ifdef XOR_ACCUM_PARITY_BIT_EN
    assign msb = ^res;
`else
    assign msb = 1'b0;
`endif

    // Three-state output stage; the result is visible continuously, including partial sums.
    assign s = EN ? {msb, res} : {(WIDTH + 1){1'bz}};

endmodule

// File: tb/tb_xor_accum_unit.sv
module tb_xor_accum_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] len = '0;
    logic       mode = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic       EN = 1'b1;
    wire  [8:0] s;

    int checks = 0;
    int errors = 0;
    logic [8:0] sb_q[$];
    logic [8:0] exp_v;
    logic [8:0] zz;

    xor_accum_unit #(.WIDTH(8), .MAX_WORDS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .mode(mode),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .busy(busy), .done(done), .EN(EN), .s(s)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] exp_bus(input logic [7:0] r);
`ifdef XOR_ACCUM_PARITY_BIT_EN
        return {^r, r};
`else
        return {1'b0, r};
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [4:0] l, input logic m);
        start = 1'b1;
        len   = l;
        mode  = m;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] d, input int gap);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        len = 5'd3;
        step();
        step();
        rst = 1'b0;
        start = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (s !== 9'h000) begin errors++; $display("FAIL reset_s got %h want 000", s); end
    endtask

    task automatic test_basic();
        sb_q.push_back(exp_bus(8'h0F ^ 8'hF0 ^ 8'h55));
        start_op(5'd3, 1'b0);
        checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_run busy=%b in_ready=%b want 1 1", busy, in_ready);
        end
        feed(8'h0F, 0);
        feed(8'hF0, 0);
        feed(8'h55, 0);
        checks++; if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_done done=%b busy=%b in_ready=%b want 1 0 0", done, busy, in_ready);
        end
        exp_v = sb_q.pop_front();
        checks++; if (s !== exp_v) begin errors++; $display("FAIL basic_s got %h want %h", s, exp_v); end
    endtask

    task automatic test_xnor_gaps();
        sb_q.push_back(exp_bus(~(8'h0F ^ 8'hF0 ^ 8'h55)));
        start_op(5'd3, 1'b1);
        feed(8'h0F, 2);
        checks++; if (s !== exp_bus(8'hF0) || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL xnor_gap_partial s=%h busy=%b done=%b want %h 1 0", s, busy, done,
                     exp_bus(8'hF0));
        end
        feed(8'hF0, 2);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL xnor_gap_stall done=%b want 0", done); end
        feed(8'h55, 0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL xnor_done got %b want 1", done); end
        exp_v = sb_q.pop_front();
        checks++; if (s !== exp_v) begin errors++; $display("FAIL xnor_s got %h want %h", s, exp_v); end
    endtask

    task automatic test_zero_len();
        sb_q.push_back(exp_bus(8'h00));
        start_op(5'd0, 1'b0);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_len_done done=%b busy=%b want 1 0", done, busy);
        end
        exp_v = sb_q.pop_front();
        checks++; if (s !== exp_v) begin errors++; $display("FAIL zero_len_s got %h want %h", s, exp_v); end
        // Back-to-back start straight from DONE.
        sb_q.push_back(exp_bus(8'h07));
        start_op(5'd1, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy); end
        feed(8'h07, 0);
        exp_v = sb_q.pop_front();
        checks++; if (s !== exp_v || done !== 1'b1) begin
            errors++; $display("FAIL parity_s got %h done=%b want %h 1", s, done, exp_v);
        end
    endtask

    task automatic test_reset_mid_run();
        start_op(5'd4, 1'b0);
        feed(8'h11, 0);
        feed(8'h22, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || s !== 9'h000) begin
            errors++;
            $display("FAIL midrun_reset in_ready=%b busy=%b done=%b s=%h want 0 0 0 000",
                     in_ready, busy, done, s);
        end
        sb_q.push_back(exp_bus(8'h3C));
        start_op(5'd1, 1'b0);
        feed(8'h3C, 0);
        exp_v = sb_q.pop_front();
        checks++; if (s !== exp_v || done !== 1'b1) begin
            errors++; $display("FAIL after_reset_s got %h done=%b want %h 1", s, done, exp_v);
        end
    endtask

    task automatic test_tristate();
        sb_q.push_back(exp_bus(8'hAA));
        start_op(5'd3, 1'b0);
        feed(8'h0F, 0);
        feed(8'hF0, 0);
        feed(8'h55, 0);
        exp_v = sb_q.pop_front();
        EN = 1'b0;
        #1;
        zz = 'z;
        checks++; if (s !== zz) begin errors++; $display("FAIL tristate_z got %b want %b", s, zz); end
        EN = 1'b1;
        #1;
        checks++; if (s !== exp_v) begin errors++; $display("FAIL tristate_back got %h want %h", s, exp_v); end
    endtask

    task automatic test_start_ignore();
        sb_q.push_back(exp_bus(8'h12 ^ 8'h34));
        start_op(5'd2, 1'b0);
        feed(8'h12, 0);
        start = 1'b1;
        len = 5'd5;
        mode = 1'b1;
        step();
        start = 1'b0;
        checks++; if (s !== exp_bus(8'h12) || busy !== 1'b1) begin
            errors++; $display("FAIL start_ignore_run s=%h busy=%b want %h 1", s, busy, exp_bus(8'h12));
        end
        feed(8'h34, 0);
        exp_v = sb_q.pop_front();
        checks++; if (s !== exp_v || done !== 1'b1) begin
            errors++; $display("FAIL start_ignore_s got %h done=%b want %h 1", s, done, exp_v);
        end
    endtask

    task automatic test_clamp();
        logic [7:0] words[16];
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            words[i] = 8'($urandom_range(0, 255));
            acc ^= words[i];
        end
        sb_q.push_back(exp_bus(acc));
        start_op(5'd31, 1'b0);
        for (int i = 0; i < 15; i++) feed(words[i], 0);
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL clamp_early done=%b busy=%b want 0 1", done, busy);
        end
        feed(words[15], 0);
        exp_v = sb_q.pop_front();
        checks++; if (s !== exp_v || done !== 1'b1) begin
            errors++; $display("FAIL clamp_s got %h done=%b want %h 1", s, done, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_xnor_gaps();
        test_zero_len();
        test_reset_mid_run();
        test_tristate();
        test_start_ignore();
        test_clamp();
        checks++; if (sb_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_left got %0d want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
